// File: rtl/shift_reg_piso_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_piso_tx_pkg
// Purpose  : Shared state encoding and sizing helpers for the PISO transmitter.
// Revision : 1.0  initial release
// ============================================================================
package shift_reg_piso_tx_pkg;

  // FSM encoding, explicit 2-bit width
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } piso_state_e;

  // Number of sdo_valid cycles per word (data bits plus optional parity bit)
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

  // Bits needed to count up to max_val inclusive, never less than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : shift_reg_piso_tx_pkg
`default_nettype wire

// File: rtl/shift_reg_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_piso_tx
// Purpose  : Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a
//            valid/ready handshake, shifts it out one bit per clk with
//            sdo_valid framing, pulses done on the final bit, then holds off
//            for GAP_CYCLES idle cycles.
// Options  : define PISO_PARITY_EN to append an even-parity bit to each frame.
// Revision : 1.0  initial release
// ============================================================================
module shift_reg_piso_tx
  import shift_reg_piso_tx_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
  localparam int CNT_W     = cnt_width(FRAME_LEN);
  localparam int GAP_W     = cnt_width(GAP_CYCLES);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

  piso_state_e      state;
  logic [WIDTH-1:0] shreg;     // bits still to be sent, head at the send end
  logic [CNT_W-1:0] bit_cnt;   // frame bits already presented on sdo, incl. current
  logic [GAP_W-1:0] gap_cnt;   // idle cycles spent in GAP, incl. current

`ifdef PISO_PARITY_EN
  logic             parity_bit;  // even parity of the captured word
`endif

  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             shreg_head;
  logic             next_bit;
  logic [WIDTH-1:0] din_rest;
  logic [WIDTH-1:0] shreg_rest;
  logic [CNT_W-1:0] bit_cnt_inc;

  // Bit-order steering: the first bit leaves straight from din at load time,
  // the remaining bits wait in shreg with the next one at the send end.
  assign first_bit  = (MSB_FIRST != 0) ? din[WIDTH-1]   : din[0];
  assign shreg_head = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign din_rest   = (MSB_FIRST != 0) ? (din << 1)     : (din >> 1);
  assign shreg_rest = (MSB_FIRST != 0) ? (shreg << 1)   : (shreg >> 1);

  assign bit_cnt_inc = bit_cnt + CNT_W'(1);

  // The cycle in which sdo carries the final frame bit
  assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);

  // Parity follows the last data bit when enabled
`ifdef PISO_PARITY_EN
  assign next_bit = (bit_cnt == CNT_W'(WIDTH)) ? parity_bit : shreg_head;
`else
  assign next_bit = shreg_head;
`endif

  // Ready in IDLE; with no gap also in the last-bit cycle so words can chain
  always_comb begin
    din_ready = 1'b0;
    if (!reset) begin
      if (state == ST_IDLE) begin
        din_ready = 1'b1;
      end else if ((GAP_CYCLES == 0) && last_bit) begin
        din_ready = 1'b1;
      end
    end
  end

  assign accept = din_valid && din_ready;

  // Transmitter FSM with registered serial outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sdo        <= 1'b0;
      sdo_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (accept) begin
      // Load: first bit goes out next cycle, whether from IDLE or chained
      state      <= ST_SHIFT;
      shreg      <= din_rest;
      bit_cnt    <= CNT_W'(1);
      gap_cnt    <= '0;
      sdo        <= first_bit;
      sdo_valid  <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_bit <= ^din;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          sdo       <= 1'b0;
          sdo_valid <= 1'b0;
          busy      <= 1'b0;
        end

        ST_SHIFT: begin
          if (!last_bit) begin
            sdo     <= next_bit;
            shreg   <= shreg_rest;
            bit_cnt <= bit_cnt_inc;
            done    <= (bit_cnt_inc == LAST_CNT);
          end else if (GAP_CYCLES > 0) begin
            state     <= ST_GAP;
            bit_cnt   <= '0;
            gap_cnt   <= GAP_W'(1);
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          bit_cnt   <= '0;
          gap_cnt   <= '0;
          sdo       <= 1'b0;
          sdo_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule : shift_reg_piso_tx
`default_nettype wire

// File: tb/tb_shift_reg_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_piso_tx
// Purpose  : Self-checking bench for shift_reg_piso_tx. Three instances:
//            a (GAP 1, MSB first), b (GAP 0, MSB first), l (GAP 3, LSB first).
//            Honours PISO_PARITY_EN in its reference frame.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_reg_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] din     = 4'h0;
  logic       a_valid = 1'b1;
  logic       b_valid = 1'b1;
  logic       l_valid = 1'b1;
  logic       sel     = 1'b0;

  logic a_ready, a_sdo, a_sv, a_busy, a_done;
  logic b_ready, b_sdo, b_sv, b_busy, b_done;
  logic l_ready, l_sdo, l_sv, l_busy, l_done;
  logic [4:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_reg_piso_tx #(.WIDTH(4), .GAP_CYCLES(1), .MSB_FIRST(1)) u_a (
    .clk(clk), .reset(reset), .din(din), .din_valid(a_valid), .din_ready(a_ready),
    .sdo(a_sdo), .sdo_valid(a_sv), .busy(a_busy), .done(a_done));

  shift_reg_piso_tx #(.WIDTH(4), .GAP_CYCLES(0), .MSB_FIRST(1)) u_b (
    .clk(clk), .reset(reset), .din(din), .din_valid(b_valid), .din_ready(b_ready),
    .sdo(b_sdo), .sdo_valid(b_sv), .busy(b_busy), .done(b_done));

  shift_reg_piso_tx #(.WIDTH(4), .GAP_CYCLES(3), .MSB_FIRST(0)) u_l (
    .clk(clk), .reset(reset), .din(din), .din_valid(l_valid), .din_ready(l_ready),
    .sdo(l_sdo), .sdo_valid(l_sv), .busy(l_busy), .done(l_done));

  // Observed bundle {sdo_valid, sdo, done, busy, din_ready} of the selected instance
  always_comb obs = sel ? {l_sv, l_sdo, l_done, l_busy, l_ready}
                        : {a_sv, a_sdo, a_done, a_busy, a_ready};

  // Reference: bit i of the frame for word w (data bits in order, then even parity)
  function automatic logic frame_bit(input logic [3:0] w, input bit msb_first, input int i);
    if (i >= 4) return ^w;
    return msb_first ? w[3-i] : w[i];
  endfunction

  // Send one word to instance a (sel=0) or l (sel=1) and check every cycle until idle again
  task automatic send_word(input string name, input bit sel_i, input logic [3:0] w, input int gap);
    logic [4:0] exp;
    logic [3:0] cap;
    int         last;
    sel = sel_i;
    @(negedge clk);
    checks++;
    if (obs[0] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready-before got=%b exp=1", name, obs[0]);
    end
    din = w;
    if (sel_i) l_valid = 1'b1; else a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    l_valid = 1'b0;
    din = 4'($urandom);
    cap = 4'h0;
    last = FRAME + gap + 1;
    for (int k = 1; k <= last; k++) begin
      exp[4] = (k <= FRAME);
      exp[3] = (k <= FRAME) ? frame_bit(w, !sel_i, k - 1) : 1'b0;
      exp[2] = (k == FRAME);
      exp[1] = (k <= FRAME + gap);
      exp[0] = (k > FRAME + gap);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cycle=%0d word=%h got{v,sdo,done,busy,rdy}=%b exp=%b", name, k, w, obs, exp);
      end
      if (obs[4] === 1'b1 && k <= 4) cap = sel_i ? {obs[3], cap[3:1]} : {cap[2:0], obs[3]};
      if (k < last) @(negedge clk);
    end
    checks++;
    if (cap !== w) begin
      errors++;
      $display("FAIL %s loopback got=%h exp=%h", name, cap, w);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 4'hF; a_valid = 1'b1; b_valid = 1'b1; l_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_sv, a_sdo, a_done, a_busy, a_ready, b_sv, b_sdo, b_done, b_busy, b_ready,
         l_sv, l_sdo, l_done, l_busy, l_ready} !== 15'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {a_sv, a_sdo, a_done, a_busy, a_ready,
               b_sv, b_sdo, b_done, b_busy, b_ready, l_sv, l_sdo, l_done, l_busy, l_ready});
    end
    a_valid = 1'b0; b_valid = 1'b0; l_valid = 1'b0; reset = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready, l_ready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=111", {a_ready, b_ready, l_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({a_sv, a_busy, b_sv, b_busy, l_sv, l_busy} !== 6'b0) begin
        errors++;
        $display("FAIL reset_no_accept got=%b exp=0", {a_sv, a_busy, b_sv, b_busy, l_sv, l_busy});
      end
    end
  endtask

  task automatic test_single_word();
    send_word("single_1011", 1'b0, 4'b1011, 1);
    send_word("loopback_0110", 1'b0, 4'b0110, 1);
    send_word("lsb_1011", 1'b1, 4'b1011, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      send_word("rand_msb", 1'b0, 4'($urandom), 1);
      send_word("rand_lsb", 1'b1, 4'($urandom), 3);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w [6];
    logic [4:0] exp;
    logic [4:0] got;
    int         sent;
    int         total;
    bit         hs;
    w[0] = 4'hA;
    w[1] = 4'h5;
    for (int i = 2; i < 6; i++) w[i] = 4'($urandom);
    total = 6 * FRAME;
    sent  = 0;
    hs    = 1'b0;
    @(negedge clk);
    din = w[0];
    b_valid = 1'b1;
    for (int c = 0; c <= total + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (hs) begin
        sent++;
        if (sent < 6) din = w[sent]; else b_valid = 1'b0;
      end
      if (c >= 1 && c <= total)
        exp = {1'b1, frame_bit(w[(c-1)/FRAME], 1'b1, (c-1)%FRAME),
               (c % FRAME == 0), 1'b1, (c % FRAME == 0)};
      else
        exp = 5'b00001;
      got = {b_sv, b_sdo, b_done, b_busy, b_ready};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle=%0d got{v,sdo,done,busy,rdy}=%b exp=%b", c, got, exp);
      end
      hs = b_valid && b_ready;
    end
  endtask

  task automatic test_mid_frame_reset();
    sel = 1'b0;
    @(negedge clk);
    din = 4'b1100;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if ({a_sv, a_sdo, a_done} !== 3'b110) begin
        errors++;
        $display("FAIL midreset_bit%0d got=%b exp=110", k, {a_sv, a_sdo, a_done});
      end
      if (k == 1) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_sv, a_sdo, a_done, a_busy, a_ready} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_abort got=%b exp=0", {a_sv, a_sdo, a_done, a_busy, a_ready});
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({a_sv, a_done, a_busy} !== 3'b0) begin
        errors++;
        $display("FAIL midreset_quiet got=%b exp=0", {a_sv, a_done, a_busy});
      end
    end
    send_word("after_reset_0011", 1'b0, 4'b0011, 1);
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    send_word("parity_0111", 1'b0, 4'b0111, 1);
    send_word("parity_0101", 1'b0, 4'b0101, 1);
    send_word("parity_lsb_1110", 1'b1, 4'b1110, 3);
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_random();
    test_back_to_back();
    test_mid_frame_reset();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_shift_reg_piso_tx
`default_nettype wire
